// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - ADC sample converter and synchronous FIFO with capture statistics
module adc_sample_fifo #(
  parameter int DW         = 12,
  parameter int AW         = 10,
  parameter int OFFSET_BIN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_otr,
  input  logic          din_valid,
  input  logic          rd_en,
  output logic [15:0]   dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic [7:0]    ovf_cnt,
  output logic          otr_seen,
  input  logic          clr_stat
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [15:0]   dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;
  logic          otr_seen_q, otr_seen_d;

  logic [DW-1:0] s;
  logic [15:0]   wr_word;
  logic          rd_ok, wr_ok, drop;
  logic [7:0]    ovf_base;

  always_comb begin
    s = din;
    if (OFFSET_BIN != 0) s[DW-1] = ~din[DW-1];
    wr_word = {din_otr, 15'($signed(s))};
  end

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it
  assign rd_ok = rd_en & ~empty_q;
  assign wr_ok = din_valid & (~full_q | rd_ok);
  assign drop  = din_valid & full_q & ~rd_ok;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dout_d       = dout_q;
    dout_valid_d = rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem[rd_ptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == FULL_LVL);
  end

  // Clear happens first so an event in the same cycle is still counted
  always_comb begin
    ovf_base  = clr_stat ? 8'd0 : ovf_cnt_q;
    ovf_cnt_d = ovf_base;
    if (drop && ovf_base != 8'hFF) ovf_cnt_d = ovf_base + 8'd1;
    otr_seen_d = (otr_seen_q & ~clr_stat) | (wr_ok & din_otr);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_cnt_q    <= '0;
      otr_seen_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_cnt_q    <= ovf_cnt_d;
      otr_seen_q   <= otr_seen_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign level      = level_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign otr_seen   = otr_seen_q;

endmodule
